// File: rtl/cache_directl1.sv
// Direct-mapped, read-only L1 cache in front of cache_directl2.
// Hits answer in one cycle. A miss issues one L2 read and fills the line after L2_LATENCY cycles.
module cache_directl1 #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 11,
    parameter int unsigned INDEX_W    = 4,
    parameter int unsigned L2_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [DATA_W-1:0] read_data,
    output logic              valid,
    output logic              hit,
    output logic              l2_read,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic [DATA_W-1:0] l2_read_data,
    input  logic              l2_hit,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned CNT_W = $clog2(L2_LATENCY + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MISS_REQ  = 2'd1;
    localparam logic [1:0] S_MISS_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              l2_read_q, l2_read_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [LINES-1:0]  line_vld_q;

    logic [INDEX_W-1:0] req_idx_c;
    logic [TAG_W-1:0]   req_tag_c;
    logic [INDEX_W-1:0] fill_idx_c;
    logic [TAG_W-1:0]   fill_tag_c;
    logic               lookup_hit_c;
    logic               fill_c;
    logic               unused_l2_hit_c;

    assign req_idx_c       = addr[INDEX_W-1:0];
    assign req_tag_c       = addr[ADDR_W-1:INDEX_W];
    assign fill_idx_c      = l2_addr_q[INDEX_W-1:0];
    assign fill_tag_c      = l2_addr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit_c    = line_vld_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
    assign unused_l2_hit_c = l2_hit;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        hit_d      = 1'b0;
        rdata_d    = rdata_q;
        l2_read_d  = 1'b0;
        l2_addr_d  = l2_addr_q;
        wait_d     = wait_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req) begin
                    if (lookup_hit_c) begin
                        valid_d   = 1'b1;
                        hit_d     = 1'b1;
                        rdata_d   = data_q[req_idx_c];
                        hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                    end else begin
                        miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                        l2_read_d  = 1'b1;
                        l2_addr_d  = addr;
                        ready_d    = 1'b0;
                        state_d    = S_MISS_REQ;
                    end
                end
            end
            S_MISS_REQ: begin
                ready_d = 1'b0;
                wait_d  = CNT_W'(L2_LATENCY);
                state_d = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (wait_q == CNT_W'(1)) begin
                    // Last wait cycle: L2 data is valid now, fill and respond
                    fill_c  = 1'b1;
                    valid_d = 1'b1;
                    rdata_d = l2_read_data;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ready_d = 1'b0;
                    wait_d  = wait_q - CNT_W'(1);
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            l2_read_q  <= 1'b0;
            l2_addr_q  <= '0;
            wait_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            line_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
            l2_read_q  <= l2_read_d;
            l2_addr_q  <= l2_addr_d;
            wait_q     <= wait_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fill_c) begin
                line_vld_q[fill_idx_c] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every lookup
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_q[fill_idx_c]  <= fill_tag_c;
            data_q[fill_idx_c] <= l2_read_data;
        end
    end

    assign ready      = ready_q;
    assign valid      = valid_q;
    assign hit        = hit_q;
    assign read_data  = rdata_q;
    assign l2_read    = l2_read_q;
    assign l2_addr    = l2_addr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule
